keypad_scanner: RTL

Debounced 4x4 matrix-keypad scanner that consumes the one-hot column phase produced by the 4-bit ring counter stage (q0..q3) and reads the keypad rows returned for the active column. It turns raw row contacts into a single 4-bit key code with a one-cycle valid strobe and a held flag. It sits directly downstream of the ring counter and feeds the display/control logic.

---
 rtl/keypad_scanner_pkg.sv | 17 +
 rtl/keypad_scanner_onehot_enc4.sv | 21 ++
 rtl/keypad_scanner.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner: FSM encoding, matrix size and
// the idle (all rows open) value of the registered row sample.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  localparam logic [NUM_ROWS-1:0] ROW_RESET = 4'hF;

endpackage

// File: rtl/keypad_scanner_onehot_enc4.sv
// 4-bit one-hot to 2-bit index encoder; valid only when exactly one bit is set.
module onehot_enc4 (
  input  logic [3:0] onehot,
  output logic [1:0] idx,
  output logic       valid
);

  always_comb begin
    idx = 2'd0;
    unique case (onehot)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  assign valid = (onehot != 4'd0) && ((onehot & (onehot - 4'd1)) == 4'd0);

endmodule

// File: rtl/keypad_scanner.sv
// Debounced 4x4 keypad scanner driven by an external ring-counter column phase.
//
// state    | meaning
// IDLE     | no key tracked, waiting for any closed contact
// DEBOUNCE | candidate seen, counting consecutive closed visits
// PRESSED  | key accepted, key_held high, waiting for an open visit
// RELEASE  | counting consecutive open visits before dropping key_held
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_COLS-1:0] col,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held,
  output logic                phase_err
);

  localparam logic [3:0] CNT_DONE = 4'(DEBOUNCE_SCANS);

  logic [NUM_COLS-1:0] col_r;
  logic [NUM_ROWS-1:0] row_r;
  logic                sample_vld;
  scan_state_t         state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic [3:0]          cand, cand_nxt;
  logic [3:0]          code_nxt;
  logic                valid_nxt, held_nxt;

  logic [1:0] col_idx;
  logic       col_ok;
  logic [1:0] row_idx;
  logic       hit;
  logic       sample_ok;
  logic       cand_col;
  logic       cand_open;
  logic [3:0] cnt_inc;

  onehot_enc4 u_col_enc (
    .onehot (col_r),
    .idx    (col_idx),
    .valid  (col_ok)
  );

  always_comb begin
    row_idx = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!row_r[i]) row_idx = 2'(i);
    end
  end

  // The reset value of col_r is not a real sample, so it must not raise phase_err.
  assign hit       = ~&row_r;
  assign sample_ok = sample_vld & col_ok;
  assign cand_col  = (col_idx == cand[1:0]);
  assign cand_open = row_r[cand[3:2]];
  assign cnt_inc   = cnt + 4'd1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    code_nxt  = key_code;
    valid_nxt = 1'b0;
    held_nxt  = key_held;
    if (sample_ok) begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            cand_nxt  = {row_idx, col_idx};
            cnt_nxt   = 4'd1;
            state_nxt = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (cand_col) begin
            if (!cand_open) begin
              cnt_nxt = cnt_inc;
              if (cnt_inc == CNT_DONE) begin
                state_nxt = PRESSED;
                code_nxt  = cand;
                valid_nxt = 1'b1;
                held_nxt  = 1'b1;
              end
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        PRESSED: begin
          if (cand_col && cand_open) begin
            cnt_nxt   = 4'd1;
            state_nxt = RELEASE;
          end
        end
        RELEASE: begin
          if (cand_col) begin
            if (cand_open) begin
              cnt_nxt = cnt_inc;
              if (cnt_inc == CNT_DONE) begin
                state_nxt = IDLE;
                held_nxt  = 1'b0;
              end
            end else begin
              state_nxt = PRESSED;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_r      <= '0;
      row_r      <= ROW_RESET;
      sample_vld <= 1'b0;
      state      <= IDLE;
      cnt        <= 4'd0;
      cand       <= 4'd0;
      key_code   <= 4'd0;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
      phase_err  <= 1'b0;
    end else begin
      col_r      <= col;
      row_r      <= row_n;
      sample_vld <= 1'b1;
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cand       <= cand_nxt;
      key_code   <= code_nxt;
      key_valid  <= valid_nxt;
      key_held   <= held_nxt;
      phase_err  <= sample_vld & ~col_ok;
    end
  end

endmodule
